// File: rtl/unipolar_rz_pkg.sv
// Shared types and timing helpers for the unipolar RZ line receiver and transmitter.
package unipolar_rz_pkg;

  typedef enum logic [1:0] {
    SYNC,
    LOW,
    HIGH
  } rz_state_e;

  // Convert a time in seconds to a whole number of clock cycles, rounded to nearest.
  function automatic int cycles(input real seconds, input int clock_rate);
    return $rtoi(seconds * real'(clock_rate) + 0.5);
  endfunction

endpackage

// File: rtl/unipolar_rz_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
module unipolar_rz_sync #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clock) begin
    if (reset) sync_q <= {2{RESET_VALUE}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/unipolar_rz_receiver.sv
// Unipolar return-to-zero receiver: measures pulse widths on the line, shifts bits
// in LSB first and presents each completed word with a one-cycle valid pulse.
module unipolar_rz_receiver
  import unipolar_rz_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  CLOCK_RATE     = 50000000,
  parameter real ZERO_HIGH_TIME = 0.4e-6,
  parameter real ONE_HIGH_TIME  = 0.8e-6,
  parameter real ZERO_LOW_TIME  = 0.85e-6,
  parameter real ONE_LOW_TIME   = 0.45e-6,
  parameter real RESET_TIME     = 50e-6,
  parameter bit  INVERT         = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  error,
  output logic                  armed
);

  localparam int ONE_THRESH   = cycles((ZERO_HIGH_TIME + ONE_HIGH_TIME) / 2.0, CLOCK_RATE);
  localparam int MAX_HIGH     = cycles(2.0 * ONE_HIGH_TIME, CLOCK_RATE);
  localparam int RESET_DETECT = cycles(RESET_TIME / 2.0, CLOCK_RATE);
  localparam int ZERO_HIGH    = cycles(ZERO_HIGH_TIME, CLOCK_RATE);
  localparam int ZERO_LOW     = cycles(ZERO_LOW_TIME, CLOCK_RATE);
  localparam int ONE_LOW      = cycles(ONE_LOW_TIME, CLOCK_RATE);
  localparam int MAX_LOW      = (ZERO_LOW > ONE_LOW) ? ZERO_LOW : ONE_LOW;
  localparam int CNT_MAX      = (MAX_HIGH > RESET_DETECT) ? MAX_HIGH : RESET_DETECT;
  localparam int CW           = $clog2(CNT_MAX + 1);
  localparam int BW           = $clog2(DATA_WIDTH + 1);

  if (RESET_DETECT <= 2 * MAX_LOW) begin : g_bad_reset_time
    $error("RESET_DETECT is too short to separate a reset gap from a bit gap");
  end
  if (ONE_THRESH <= ZERO_HIGH) begin : g_bad_threshold
    $error("ONE_THRESH does not lie above the zero-bit high time");
  end

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic line_s;
  logic ls;
  logic lq_q;
  logic rise;
  logic fall;

  unipolar_rz_sync #(.RESET_VALUE(INVERT)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (line),
    .q     (line_s)
  );

  assign ls   = line_s ^ INVERT;
  assign rise = ls & ~lq_q;
  assign fall = ~ls & lq_q;

  rz_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  error_q, error_d;
  logic                  armed_q, armed_d;
  logic                  new_bit;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    error_d      = 1'b0;
    armed_d      = armed_q;
    cnt_inc      = sat_inc(cnt_q);
    new_bit      = (cnt_q >= CW'(ONE_THRESH));

    unique case (state_q)
      SYNC: begin
        if (ls) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(RESET_DETECT)) begin
            state_d   = LOW;
            armed_d   = 1'b1;
            bit_cnt_d = '0;
            cnt_d     = '0;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_inc;
          // A reset gap only flags an error when it cuts a word short.
          if (cnt_inc == CW'(RESET_DETECT) && cnt_q != CW'(RESET_DETECT)) begin
            error_d   = (bit_cnt_q != '0);
            bit_cnt_d = '0;
          end
        end
      end
      HIGH: begin
        if (fall) begin
          shift_d = DATA_WIDTH'({new_bit, shift_q} >> 1);
          cnt_d   = '0;
          state_d = LOW;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d    = '0;
            data_d       = shift_d;
            data_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc > CW'(MAX_HIGH)) begin
            error_d   = 1'b1;
            armed_d   = 1'b0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = SYNC;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SYNC;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
      armed_q      <= 1'b0;
      lq_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
      armed_q      <= armed_d;
      lq_q         <= ls;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign error      = error_q;
  assign armed      = armed_q;

endmodule

// File: doc/unipolar_rz_receiver.md
Name: unipolar_rz_receiver

Overview:
- Decodes a unipolar return-to-zero serial line, such as a WS2812-style LED chain, back into parallel words.
- Bits arrive LSB first. Each bit is one high pulse followed by a low gap; a long low gap marks a reset/frame boundary.
- Sits at the far end of the line from the RZ transmitter. It is used for loopback checking, daisy-chain snooping, and driving decoded data into downstream logic.
- Words may arrive back-to-back with no reset gap between them, so framing is done by bit count.

Parameters:
- DATA_WIDTH, 8, bits per word.
- CLOCK_RATE, 50000000, clock frequency in Hz.
- ZERO_HIGH_TIME, 0.4e-6, nominal high time of a 0 bit, in seconds.
- ONE_HIGH_TIME, 0.8e-6, nominal high time of a 1 bit, in seconds.
- ZERO_LOW_TIME, 0.85e-6, nominal low time after a 0 bit, in seconds.
- ONE_LOW_TIME, 0.45e-6, nominal low time after a 1 bit, in seconds.
- RESET_TIME, 50e-6, nominal reset low time, in seconds.
- INVERT, 0, when 1 the line is active-low and the receiver inverts it internally.

Ports:
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- line  input  1  asynchronous serial line.
- data  output  DATA_WIDTH  last complete word; first received bit in data[0].
- data_valid  output  1  one-cycle pulse when data updates.
- error  output  1  one-cycle pulse on a framing error.
- armed  output  1  high while synchronised to the line.

Behaviour:
- Clocking and reset (already decided): one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset values: data=0, data_valid=0, error=0, armed=0. Also: state=SYNC, bit count=0, counters=0, synchroniser flops=INVERT.
- Input path: 2-flop synchroniser, then XOR with INVERT, giving `ls`. `lq` is `ls` registered one cycle.
  - Rising edge: ls=1 while lq=0. Falling edge: ls=0 while lq=1.
- Derived constants (elaboration time, rounded to nearest integer cycle):
  - ONE_THRESH = CLOCK_RATE*(ZERO_HIGH_TIME+ONE_HIGH_TIME)/2 (30 at defaults).
  - MAX_HIGH = 2*CLOCK_RATE*ONE_HIGH_TIME (80).
  - RESET_DETECT = CLOCK_RATE*RESET_TIME/2 (1250).
  - Elaboration $error if RESET_DETECT <= 2*max(ZERO_LOW, ONE_LOW) cycles, or if ONE_THRESH <= ZERO_HIGH cycles.
- Counter sizing: a single run counter, width $clog2(max(MAX_HIGH, RESET_DETECT)+1). It saturates and never wraps.
- States:
  - SYNC: count cycles with ls=0; any ls=1 clears the count. Count reaching RESET_DETECT → LOW, armed=1, bit count=0.
  - LOW: count cycles with ls=0.
    - Rising edge → HIGH, counter=1.
    - Count reaching RESET_DETECT with bit count≠0 → error pulse, bit count=0, stay in LOW. With bit count=0 this is silent.
  - HIGH: counter increments while ls=1.
    - Counter exceeding MAX_HIGH → error pulse, armed=0, bit count=0, → SYNC.
    - Falling edge → bit = (counter >= ONE_THRESH). The bit shifts into the shift register MSB with a right shift, bit count increments, counter=0, → LOW.
- Word completion: when the falling edge completes bit DATA_WIDTH, in the next cycle data=shift register value and data_valid=1.
  - Bit count returns to 0 in the same cycle.
  - No reset gap is needed before the next word.
- Latency: data_valid rises exactly 1 cycle after the cycle in which the final falling edge is visible on ls.
- Priority: reset overrides everything. Within a cycle, an edge is evaluated before the counter limit checks.
- data holds its value between words. A partial word never updates data.
- error and data_valid are never high in the same cycle.

Decomposition:
- Package unipolar_rz_pkg holds:
  - the state enum (SYNC, LOW, HIGH);
  - a function cycles(real seconds, int clock_rate) returning an int rounded to nearest, shared with the transmitter.
- Sub-module unipolar_rz_sync: 2-flop synchroniser with a reset value parameter.

Test Plan:
- Default parameters, INVERT=0. Reset, then 1250 low cycles → armed=1. Send 0xA5 LSB first (1 = 40 high/22 low, 0 = 20 high/42 low) → data=8'hA5, one data_valid pulse, error never high.
- 0x01 then 0xFE back-to-back with no gap → two data_valid pulses, data 8'h01 then 8'hFE, each 1 cycle after the final falling edge.
- Threshold boundary: a word whose bit0 high is 29 cycles and bit1 high is 30 cycles, rest zeros → data=8'h02.
- 3 bits sent, then line low 1250 cycles → error pulse at exactly 1250 low cycles on ls, no data_valid, data unchanged. A following 0x3C → data=8'h3C.
- Line held high 81 cycles → error pulse, armed=0. Pulses without a prior ≥1250-cycle gap yield no data_valid. After the gap plus 0x55 → data=8'h55.
- INVERT=1 with the line polarity flipped repeats the first case → 8'hA5. Asserting reset mid-word → all outputs 0 next cycle, armed=0.
